carrier_freq_search: RTL and testbench
======================================

# carrier_freq_search

Coarse carrier-frequency acquisition stage that sits directly upstream of the Costas loop and generates its 32-bit initial NCO phase increment. It counts rising mid-scale crossings of the 8-bit ADC stream over a power-of-two sample window. It converts the count to a phase increment with a shift, so no divider is needed. The result is presented as `freq_inc`, which feeds the Costas `initial_freq` input in place of the fixed constant. A `rearm` input restarts acquisition, for example on loss of lock.

## Interface
- `WIN_LOG2`, 16: log2 of the measurement window in samples. Legal range is 8..24.
- `SETTLE`, 1024: idle cycles before each measurement. Must be ≥ 1.
- `HYST`, 8: comparator hysteresis half-width, in LSB.
- `MID`, 128: mid-scale code of the offset-binary ADC.
- `MIN_CROSS`, 16: minimum crossing count accepted as a valid signal.
- `DEFAULT_INC`, 32'd143165577: reset value of `freq_inc`. This is 1 MHz at 30 MHz.
- `clk_30m`, input, 1: sample clock, 30 MHz.
- `rst`, input, 1: asynchronous, active-low reset.
- `ad_data`, input, 8: ADC sample, offset binary.
- `rearm`, input, 1: single-cycle pulse that restarts acquisition.
- `freq_inc`, output, 32: NCO phase increment. Held between updates.
- `freq_valid`, output, 1: one-cycle pulse when `freq_inc` is updated.
- `no_signal`, output, 1: high when the last window ended with fewer than `MIN_CROSS` crossings.
- `busy`, output, 1: high in the SETTLE and MEAS states.

## Operation
- **Input register:** `ad_data` is registered once as `s`. All logic uses `s`.
- **Comparator `cmp`:** with hysteresis, see Configuration.
- **Crossing event:** `cmp` goes 0→1 in a cycle where the state is MEAS.
- **FSM states:** SETTLE, MEAS, LOAD, DONE. The reset state is SETTLE.
  - SETTLE: the settle counter counts `SETTLE` cycles, then the FSM moves to MEAS. The crossing counter `C` and the sample counter are cleared on entry.
  - MEAS: runs for exactly 2^`WIN_LOG2` cycles. `C` is incremented on each crossing event. `C` is `WIN_LOG2` bits wide and cannot overflow, because the maximum count is 2^(`WIN_LOG2`-1).
  - LOAD: lasts one cycle.
    - If `C` ≥ `MIN_CROSS`: `freq_inc` ← `C` << (32-`WIN_LOG2`), truncated to 32 bits. `freq_valid` = 1 and `no_signal` ← 0.
    - Otherwise: `freq_inc` is unchanged, `freq_valid` = 0 and `no_signal` ← 1.
    - Next state is DONE.
  - DONE: holds until `rearm`, then moves to SETTLE.
- **Rearm:**
  - `rearm` in SETTLE, MEAS or DONE forces SETTLE on the next edge, with counters cleared. A partial window is discarded and `freq_inc` is unchanged.
  - `rearm` in the LOAD cycle: the load completes, then the next state is SETTLE instead of DONE.
- **Reset mid-operation:** immediately restores all reset values and discards any partial count.
- **`cmp` tracking:** `cmp` follows `s` in every state, so the first MEAS cycle can count an edge from SETTLE→MEAS.

## Timing
- **Reset values:** `freq_inc` = `DEFAULT_INC`, `freq_valid` = 0, `no_signal` = 0, `busy` = 1, `cmp` = 0, state SETTLE.
- **Data latency:** a change on `ad_data` reaches `s` after 1 edge and `cmp` after 2 edges.
- **Acquisition time:** after reset release or a `rearm` edge, `freq_valid` asserts in the cycle following SETTLE + 2^`WIN_LOG2` cycles. For the defaults this is 1024 + 65536 cycles, about 2.22 ms.
- **Update alignment:** `freq_inc` changes on the same edge that raises `freq_valid`, and is stable for at least 1 cycle before the FSM can update it again.
- **`busy`:** deasserts on the edge entering LOAD.

## Configuration
- **`FSEARCH_HYST_EN` defined:** Schmitt comparator.
  - `cmp` ← 1 when `s` ≥ `MID`+`HYST`.
  - `cmp` ← 0 when `s` < `MID`-`HYST`.
  - Otherwise `cmp` holds its value.
- **`FSEARCH_HYST_EN` undefined:** plain comparator, `cmp` ← (`s` ≥ `MID`), and `HYST` is ignored.

## Test plan
- **1 MHz square wave:** square wave of 128±100 with a period of 30 samples, defaults, macro on → exactly one `freq_valid` pulse, `freq_inc` ∈ {143130624, 143196160} (`C` = 2184 or 2185), `no_signal` = 0.
- **Constant input:** `ad_data` = 128 → no `freq_valid`, `no_signal` = 1, `freq_inc` remains 143165577.
- **Small-noise input:** `ad_data` alternating 124/132 every sample → with `FSEARCH_HYST_EN`, `C` = 0 and `no_signal` = 1. Without the macro, `C` = 32768 and `freq_inc` = 32'h80000000.
- **Rearm mid-window:** `rearm` pulsed mid-window (e.g. 30000 cycles into MEAS) after a 1 MHz lock, with input switched to a 2 MHz tone (period 15) → the partial window is discarded. `freq_valid` occurs SETTLE + 65536 cycles after `rearm`, with `freq_inc` ≈ 286326784 (`C` = 4369).
- **Rearm during LOAD:** `rearm` coincident with the LOAD cycle → `freq_valid` pulses and `freq_inc` updates, and the next state is SETTLE with `busy` = 1.
- **Reset during MEAS:** `rst` asserted during MEAS → all outputs return to reset values immediately, and a fresh acquisition completes after release.

Source files
------------

// File: rtl/carrier_freq_search.sv
// carrier_freq_search: coarse carrier acquisition ahead of the Costas loop.
// Counts rising mid-scale crossings of the ADC stream over 2^WIN_LOG2 samples
// and turns the count into a 32-bit NCO phase increment by a shift.
// Optional feature macro: FSEARCH_HYST_EN (Schmitt comparator with +/-HYST).
module carrier_freq_search #(
   parameter int          WIN_LOG2    = 16,
   parameter int          SETTLE      = 1024,
   parameter int          HYST        = 8,
   parameter int          MID         = 128,
   parameter int          MIN_CROSS   = 16,
   parameter logic [31:0] DEFAULT_INC = 32'd143165577
) (
   input  logic        clk_30m,
   input  logic        rst,
   input  logic [7:0]  ad_data,
   input  logic        rearm,
   output logic [31:0] freq_inc,
   output logic        freq_valid,
   output logic        no_signal,
   output logic        busy
);

   typedef enum logic [1:0] {ST_SETTLE, ST_MEAS, ST_LOAD, ST_DONE} state_t;

`ifdef FSEARCH_HYST_EN
   localparam int HYST_EN = 1;
`else
   localparam int HYST_EN = 0;
`endif

   // With hysteresis disabled both thresholds collapse onto MID, which makes
   // the Schmitt comparator below a plain s >= MID comparator.
   localparam int               HW         = HYST * HYST_EN;
   localparam logic [9:0]       TH_HI      = 10'(MID + HW);
   localparam logic [9:0]       TH_LO      = 10'(MID - HW);
   localparam logic [31:0]      SETTLE_LST = 32'(SETTLE - 1);
   localparam logic [31:0]      WIN_LST    = (32'd1 << WIN_LOG2) - 32'd1;
   localparam logic [WIN_LOG2-1:0] MIN_C   = WIN_LOG2'(MIN_CROSS);

   state_t              state;
   logic [7:0]          s;
   logic                cmp, cmp_nxt;
   logic [31:0]         cnt;
   logic [WIN_LOG2-1:0] c, c_nxt;

   // Comparator next value: set at/above upper threshold, clear below lower, else hold
   always_comb begin
      cmp_nxt = cmp;
      if ({2'b00, s} >= TH_HI)
         cmp_nxt = 1'b1;
      else if ({2'b00, s} < TH_LO)
         cmp_nxt = 1'b0;
   end

   // Crossing count including a rising edge of cmp happening in this MEAS cycle
   always_comb begin
      c_nxt = c;
      if (state == ST_MEAS && !cmp && cmp_nxt)
         c_nxt = c + 1'b1;
   end

   // Input register and comparator state; cmp tracks s in every FSM state
   always_ff @(posedge clk_30m or negedge rst) begin
      if (!rst) begin
         s   <= '0;
         cmp <= 1'b0;
      end else begin
         s   <= ad_data;
         cmp <= cmp_nxt;
      end
   end

   // Acquisition FSM with registered outputs; the result is loaded on the
   // edge entering LOAD so freq_valid is visible during the LOAD cycle
   always_ff @(posedge clk_30m or negedge rst) begin
      if (!rst) begin
         state      <= ST_SETTLE;
         cnt        <= '0;
         c          <= '0;
         freq_inc   <= DEFAULT_INC;
         freq_valid <= 1'b0;
         no_signal  <= 1'b0;
         busy       <= 1'b1;
      end else begin
         freq_valid <= 1'b0;
         case (state)
            ST_SETTLE: begin
               c <= '0;
               if (rearm)
                  cnt <= '0;
               else if (cnt == SETTLE_LST) begin
                  state <= ST_MEAS;
                  cnt   <= '0;
               end else
                  cnt <= cnt + 32'd1;
            end
            ST_MEAS: begin
               if (rearm) begin
                  // partial window is dropped, freq_inc untouched
                  state <= ST_SETTLE;
                  cnt   <= '0;
                  c     <= '0;
               end else if (cnt == WIN_LST) begin
                  state <= ST_LOAD;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  c     <= c_nxt;
                  if (c_nxt >= MIN_C) begin
                     freq_inc   <= {c_nxt, {(32-WIN_LOG2){1'b0}}};
                     freq_valid <= 1'b1;
                     no_signal  <= 1'b0;
                  end else
                     no_signal  <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
                  c   <= c_nxt;
               end
            end
            ST_LOAD: begin
               state <= rearm ? ST_SETTLE : ST_DONE;
               busy  <= rearm;
               cnt   <= '0;
            end
            ST_DONE: begin
               if (rearm) begin
                  state <= ST_SETTLE;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= ST_SETTLE;
               busy  <= 1'b1;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_carrier_freq_search.sv
// Directed bench for carrier_freq_search with a small window so each
// acquisition is SETTLE + 2^WIN_LOG2 = 272 cycles. Expected load results are
// queued when the stimulus is chosen and popped when the DUT enters LOAD.
module tb_carrier_freq_search;

   localparam int          W    = 8;
   localparam int          ST   = 16;
   localparam int          MINC = 16;
   localparam logic [31:0] DEF  = 32'd143165577;
   localparam int          NACQ = ST + (1 << W);

   logic        clk_30m = 1'b0;
   logic        rst;
   logic [7:0]  ad_data;
   logic        rearm;
   logic [31:0] freq_inc;
   logic        freq_valid, no_signal, busy;

   typedef struct packed {
      logic [31:0] inc;
      logic        vld;
      logic        nos;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int          mode  = 0;
   int          per   = 8;
   int          ph    = 0;
   int          n;
   logic [31:0] cur_inc;

   carrier_freq_search #(
      .WIN_LOG2(W), .SETTLE(ST), .HYST(8), .MID(128),
      .MIN_CROSS(MINC), .DEFAULT_INC(DEF)
   ) dut (
      .clk_30m(clk_30m), .rst(rst), .ad_data(ad_data), .rearm(rearm),
      .freq_inc(freq_inc), .freq_valid(freq_valid),
      .no_signal(no_signal), .busy(busy)
   );

   always #5 clk_30m = ~clk_30m;

   // mode 0: constant mid-scale, 1: 128+/-100 square of period per, 2: 124/132 alternating
   function automatic logic [7:0] gen();
      case (mode)
         0:       return 8'd128;
         1:       return ((ph % per) < (per / 2)) ? 8'd228 : 8'd28;
         default: return ph[0] ? 8'd132 : 8'd124;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_30m);
      #1;
      ph++;
      ad_data = gen();
   endtask

   task automatic wait_load(output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (busy && cnt < 2000);
   endtask

   task automatic push(input logic [31:0] inc, input logic vld, input logic nos);
      exp_t e;
      e.inc = inc; e.vld = vld; e.nos = nos;
      sb.push_back(e);
   endtask

   task automatic check_load(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_valid"}, {31'd0, freq_valid}, {31'd0, e.vld});
         chk({tag, "_inc"},   freq_inc,            e.inc);
         chk({tag, "_nosig"}, {31'd0, no_signal},  {31'd0, e.nos});
      end
   endtask

   task automatic do_rearm();
      rearm = 1'b1;
      tick();
      rearm = 1'b0;
   endtask

   initial begin
      rst = 1'b0; rearm = 1'b0; ad_data = 8'd128;
      repeat (3) tick();
      chk("rst_inc",   freq_inc, DEF);
      chk("rst_valid", {31'd0, freq_valid}, 32'd0);
      chk("rst_nosig", {31'd0, no_signal}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd1);

      // square wave period 8: 32 rising crossings -> 32 << 24
      mode = 1; per = 8; ad_data = gen();
      rst = 1'b1;
      cur_inc = 32'h2000_0000;
      push(cur_inc, 1'b1, 1'b0);
      wait_load(n);
      chk("sq8_latency", n, NACQ);
      check_load("sq8");
      tick();
      chk("sq8_pulse_end", {31'd0, freq_valid}, 32'd0);
      chk("sq8_done_busy", {31'd0, busy}, 32'd0);
      repeat (5) tick();
      chk("sq8_hold_inc", freq_inc, cur_inc);

      // constant mid-scale: no crossings, freq_inc held
      mode = 0;
      do_rearm();
      chk("const_busy", {31'd0, busy}, 32'd1);
      push(cur_inc, 1'b0, 1'b1);
      wait_load(n);
      chk("const_latency", n, NACQ);
      check_load("const");

      // small noise around mid-scale
      mode = 2;
      do_rearm();
`ifdef FSEARCH_HYST_EN
      push(cur_inc, 1'b0, 1'b1);
`else
      cur_inc = 32'h8000_0000;
      push(cur_inc, 1'b1, 1'b0);
`endif
      wait_load(n);
      chk("noise_latency", n, NACQ);
      check_load("noise");

      // rearm mid-window, input switched to period 4 (64 crossings)
      mode = 1; per = 8;
      do_rearm();
      repeat (ST + 100) tick();
      chk("mid_busy", {31'd0, busy}, 32'd1);
      per = 4;
      do_rearm();
      cur_inc = 32'h4000_0000;
      push(cur_inc, 1'b1, 1'b0);
      wait_load(n);
      chk("mid_latency", n, NACQ);
      check_load("mid");

      // rearm coincident with LOAD
      per = 8;
      do_rearm();
      cur_inc = 32'h2000_0000;
      push(cur_inc, 1'b1, 1'b0);
      wait_load(n);
      chk("ldre_latency", n, NACQ);
      check_load("ldre");
      per = 4;
      do_rearm();
      chk("ldre_busy", {31'd0, busy}, 32'd1);
      chk("ldre_valid", {31'd0, freq_valid}, 32'd0);
      chk("ldre_inc", freq_inc, cur_inc);
      cur_inc = 32'h4000_0000;
      push(cur_inc, 1'b1, 1'b0);
      wait_load(n);
      chk("ldre2_latency", n, NACQ);
      check_load("ldre2");

      // get no_signal high, then reset in the middle of MEAS
      mode = 0;
      do_rearm();
      push(cur_inc, 1'b0, 1'b1);
      wait_load(n);
      check_load("pre_rst");
      mode = 1; per = 8;
      do_rearm();
      repeat (ST + 100) tick();
      rst = 1'b0;
      #1;
      chk("mrst_inc",   freq_inc, DEF);
      chk("mrst_valid", {31'd0, freq_valid}, 32'd0);
      chk("mrst_nosig", {31'd0, no_signal}, 32'd0);
      chk("mrst_busy",  {31'd0, busy}, 32'd1);
      repeat (3) tick();
      rst = 1'b1;
      cur_inc = 32'h2000_0000;
      push(cur_inc, 1'b1, 1'b0);
      wait_load(n);
      chk("mrst_latency", n, NACQ);
      check_load("mrst");
      tick();
      chk("mrst_pulse_end", {31'd0, freq_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
